// File: rtl/dmem_cache.sv
// dmem_cache: direct-mapped, write-through, write-allocate data cache.
// Optional hit/miss/write counters: define DMEM_CACHE_STATS_EN.
module dmem_cache #(
  parameter int ADDR_W     = 32,
  parameter int DATA_W     = 32,
  parameter int INDEX_BITS = 6
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              cpu_req,
  input  logic              cpu_we,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [DATA_W-1:0] cpu_wdata,
  output logic [DATA_W-1:0] cpu_rdata,
  output logic              cpu_ready,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  input  logic              mem_ack
`ifdef DMEM_CACHE_STATS_EN
  ,
  output logic [31:0]       rd_hit_cnt,
  output logic [31:0]       rd_miss_cnt,
  output logic [31:0]       wr_cnt
`endif
);

  localparam int TAG_W = ADDR_W - INDEX_BITS - 2;
  localparam int LINES = 1 << INDEX_BITS;

  typedef enum logic [1:0] {
    S_IDLE,
    S_RD_MISS,
    S_WR_THRU
  } state_t;

  state_t state_q;

  logic [LINES-1:0]  valid_q;
  logic [TAG_W-1:0]  tag_q  [LINES];
  logic [DATA_W-1:0] data_q [LINES];

  logic              cpu_ready_q;
  logic [DATA_W-1:0] cpu_rdata_q;
  logic              mem_req_q;
  logic              mem_we_q;
  logic [ADDR_W-1:0] mem_addr_q;
  logic [DATA_W-1:0] mem_wdata_q;

  logic [INDEX_BITS-1:0] req_idx;
  logic [TAG_W-1:0]      req_tag;
  logic [INDEX_BITS-1:0] fill_idx;
  logic [TAG_W-1:0]      fill_tag;
  logic [ADDR_W-1:0]     req_addr_d;
  logic                  hit;
  logic                  accept;

  logic                  arr_we;
  logic [INDEX_BITS-1:0] arr_idx;
  logic [TAG_W-1:0]      arr_tag;
  logic [DATA_W-1:0]     arr_data;

  // byte-offset bits play no part in a word cache
  logic unused_addr_bits;
  assign unused_addr_bits = ^cpu_addr[1:0];

  assign req_idx    = cpu_addr[INDEX_BITS+1:2];
  assign req_tag    = cpu_addr[ADDR_W-1:INDEX_BITS+2];
  assign req_addr_d = {cpu_addr[ADDR_W-1:2], 2'b00};

  // a pending miss is refilled from the address it sent to memory
  assign fill_idx = mem_addr_q[INDEX_BITS+1:2];
  assign fill_tag = mem_addr_q[ADDR_W-1:INDEX_BITS+2];

  assign hit = valid_q[req_idx] && (tag_q[req_idx] == req_tag);

  // cpu_ready_q high means the last completion is still showing
  assign accept = (state_q == S_IDLE) && cpu_req && !cpu_ready_q;

  // line update source: write allocate at accept, refill on miss ack
  always_comb begin
    arr_we   = 1'b0;
    arr_idx  = req_idx;
    arr_tag  = req_tag;
    arr_data = cpu_wdata;
    if (accept && cpu_we) begin
      arr_we = 1'b1;
    end else if (state_q == S_RD_MISS && mem_ack) begin
      arr_we   = 1'b1;
      arr_idx  = fill_idx;
      arr_tag  = fill_tag;
      arr_data = mem_rdata;
    end
  end

  // tag/data storage, no reset; VALID guards stale contents
  always_ff @(posedge clk) begin
    if (arr_we && !reset) begin
      tag_q[arr_idx]  <= arr_tag;
      data_q[arr_idx] <= arr_data;
    end
  end

  // control FSM with registered CPU and memory-side outputs
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= S_IDLE;
      valid_q     <= '0;
      cpu_ready_q <= 1'b0;
      cpu_rdata_q <= '0;
      mem_req_q   <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
    end else begin
      cpu_ready_q <= 1'b0;
      if (arr_we) begin
        valid_q[arr_idx] <= 1'b1;
      end
      unique case (state_q)
        S_IDLE: begin
          if (accept) begin
            if (cpu_we) begin
              mem_req_q   <= 1'b1;
              mem_we_q    <= 1'b1;
              mem_addr_q  <= req_addr_d;
              mem_wdata_q <= cpu_wdata;
              state_q     <= S_WR_THRU;
            end else if (hit) begin
              cpu_rdata_q <= data_q[req_idx];
              cpu_ready_q <= 1'b1;
            end else begin
              mem_req_q  <= 1'b1;
              mem_we_q   <= 1'b0;
              mem_addr_q <= req_addr_d;
              state_q    <= S_RD_MISS;
            end
          end
        end
        S_RD_MISS: begin
          if (mem_ack) begin
            cpu_rdata_q <= mem_rdata;
            cpu_ready_q <= 1'b1;
            mem_req_q   <= 1'b0;
            state_q     <= S_IDLE;
          end
        end
        S_WR_THRU: begin
          if (mem_ack) begin
            cpu_ready_q <= 1'b1;
            mem_req_q   <= 1'b0;
            mem_we_q    <= 1'b0;
            state_q     <= S_IDLE;
          end
        end
        default: begin
          state_q <= S_IDLE;
        end
      endcase
    end
  end

  assign cpu_ready = cpu_ready_q;
  assign cpu_rdata = cpu_rdata_q;
  assign mem_req   = mem_req_q;
  assign mem_we    = mem_we_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;

`ifdef DMEM_CACHE_STATS_EN
  logic [31:0] hit_cnt_q;
  logic [31:0] miss_cnt_q;
  logic [31:0] wr_cnt_q;
  logic        ev_hit;
  logic        ev_miss;
  logic        ev_wr;

  assign ev_hit  = accept && !cpu_we && hit;
  assign ev_miss = accept && !cpu_we && !hit;
  assign ev_wr   = accept && cpu_we;

  // saturating event counters, bumped on the accept edge
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      hit_cnt_q  <= '0;
      miss_cnt_q <= '0;
      wr_cnt_q   <= '0;
    end else begin
      if (ev_hit && hit_cnt_q != 32'hFFFF_FFFF) begin
        hit_cnt_q <= hit_cnt_q + 32'd1;
      end
      if (ev_miss && miss_cnt_q != 32'hFFFF_FFFF) begin
        miss_cnt_q <= miss_cnt_q + 32'd1;
      end
      if (ev_wr && wr_cnt_q != 32'hFFFF_FFFF) begin
        wr_cnt_q <= wr_cnt_q + 32'd1;
      end
    end
  end

  assign rd_hit_cnt  = hit_cnt_q;
  assign rd_miss_cnt = miss_cnt_q;
  assign wr_cnt      = wr_cnt_q;
`endif

endmodule

// File: tb/tb_dmem_cache.sv
// tb_dmem_cache: random + directed scoreboard bench for dmem_cache.
// Build with DMEM_CACHE_STATS_EN to also check the counters.
module tb_dmem_cache;

  localparam int AW = 32;
  localparam int DW = 32;
  localparam int IB = 6;
  localparam int TW = AW - IB - 2;
  localparam int NL = 1 << IB;

  logic          clk = 1'b0;
  logic          reset;
  logic          cpu_req;
  logic          cpu_we;
  logic [AW-1:0] cpu_addr;
  logic [DW-1:0] cpu_wdata;
  logic [DW-1:0] cpu_rdata;
  logic          cpu_ready;
  logic          mem_req;
  logic          mem_we;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata;
  logic [DW-1:0] mem_rdata;
  logic          mem_ack;
`ifdef DMEM_CACHE_STATS_EN
  logic [31:0]   rd_hit_cnt;
  logic [31:0]   rd_miss_cnt;
  logic [31:0]   wr_cnt;
`endif

  dmem_cache #(.ADDR_W(AW), .DATA_W(DW), .INDEX_BITS(IB)) dut (
    .clk       (clk),
    .reset     (reset),
    .cpu_req   (cpu_req),
    .cpu_we    (cpu_we),
    .cpu_addr  (cpu_addr),
    .cpu_wdata (cpu_wdata),
    .cpu_rdata (cpu_rdata),
    .cpu_ready (cpu_ready),
    .mem_req   (mem_req),
    .mem_we    (mem_we),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_rdata (mem_rdata),
    .mem_ack   (mem_ack)
`ifdef DMEM_CACHE_STATS_EN
    ,
    .rd_hit_cnt  (rd_hit_cnt),
    .rd_miss_cnt (rd_miss_cnt),
    .wr_cnt      (wr_cnt)
`endif
  );

  always #5 clk = ~clk;

  int vectors = 0;
  int miscompares = 0;

  task automatic chk_eq(input string name, input logic [31:0] act,
                        input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  typedef struct {
    bit          we;
    logic [31:0] data;
    bit          hit;
    int          lat;
    longint      t;
  } exp_t;

  typedef struct {
    bit          we;
    logic [31:0] addr;
    logic [31:0] wdata;
  } mexp_t;

  exp_t  exp_q[$];
  mexp_t mexp_q[$];

  // reference: flat word memory plus which tag each line holds
  logic [31:0] ref_mem [logic [31:0]];
  bit          ref_v   [NL];
  logic [TW-1:0] ref_t [NL];
  int n_hit = 0;
  int n_miss = 0;
  int n_wr = 0;

  // environment: the backing memory seen by the responder
  logic [31:0] bmem [logic [31:0]];
  bit hold_ack = 1'b0;

  function automatic logic [31:0] init_word(input logic [31:0] wa);
    return (wa * 32'h9E37_79B1) ^ 32'h5A5A_1234;
  endfunction

  function automatic logic [31:0] ref_rd(input logic [31:0] wa);
    if (ref_mem.exists(wa)) return ref_mem[wa];
    return init_word(wa);
  endfunction

  function automatic logic [31:0] bmem_rd(input logic [31:0] wa);
    if (bmem.exists(wa)) return bmem[wa];
    return init_word(wa);
  endfunction

  task automatic wait_ready();
    int n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!cpu_ready && n < 100);
    if (!cpu_ready) chk_eq("ready_timeout", 32'd0, 32'd1);
  endtask

  task automatic do_op(input bit we, input logic [31:0] a,
                       input logic [31:0] d, input bit b2b,
                       input bit wait_done);
    int unsigned idx;
    logic [TW-1:0] tag;
    logic [31:0] wa;
    exp_t e;
    idx = int'(a[IB+1:2]);
    tag = a[AW-1:IB+2];
    wa  = {a[31:2], 2'b00};
    if (!b2b) begin
      cpu_req = 1'b0;
      repeat ($urandom_range(1, 2)) @(negedge clk);
    end
    cpu_req   = 1'b1;
    cpu_we    = we;
    cpu_addr  = a;
    cpu_wdata = d;
    e.we  = we;
    e.hit = !we && ref_v[idx] && (ref_t[idx] == tag);
    e.lat = b2b ? 2 : 1;
    e.t   = longint'($time);
    e.data = '0;
    if (we) begin
      ref_mem[wa] = d;
      ref_v[idx]  = 1'b1;
      ref_t[idx]  = tag;
      mexp_q.push_back('{we: 1'b1, addr: wa, wdata: d});
      n_wr++;
    end else begin
      e.data = ref_rd(wa);
      if (e.hit) begin
        n_hit++;
      end else begin
        ref_v[idx] = 1'b1;
        ref_t[idx] = tag;
        mexp_q.push_back('{we: 1'b0, addr: wa, wdata: 32'd0});
        n_miss++;
      end
    end
    exp_q.push_back(e);
    if (wait_done) wait_ready();
  endtask

  // CPU-side monitor: pops one expectation per completion pulse
  initial begin
    exp_t e;
    int lat;
    forever begin
      @(negedge clk);
      if (!reset && cpu_ready) begin
        if (exp_q.size() == 0) begin
          chk_eq("unexpected_ready", 32'd1, 32'd0);
        end else begin
          e = exp_q.pop_front();
          lat = int'((longint'($time) - e.t) / 10);
          if (!e.we) chk_eq("rdata", cpu_rdata, e.data);
          if (e.hit) chk_eq("hit_latency", lat, e.lat);
          else chk_eq("miss_latency_ge2", 32'(lat >= 2), 32'd1);
        end
      end
    end
  end

  // memory responder and memory-side monitor
  initial begin
    bit busy;
    bit acked;
    int cnt;
    mexp_t cur;
    busy = 1'b0;
    acked = 1'b0;
    cnt = 0;
    mem_ack = 1'b0;
    mem_rdata = '0;
    forever begin
      @(negedge clk);
      mem_ack = 1'b0;
      if (reset || !mem_req) busy = 1'b0;
      if (!reset && mem_req && !busy) begin
        busy  = 1'b1;
        acked = 1'b0;
        cnt   = $urandom_range(0, 3);
        if (mexp_q.size() == 0) begin
          chk_eq("unexpected_mem_req", 32'd1, 32'd0);
          cur = '{we: mem_we, addr: mem_addr, wdata: mem_wdata};
        end else begin
          cur = mexp_q.pop_front();
          chk_eq("mem_we", 32'(mem_we), 32'(cur.we));
          chk_eq("mem_addr", mem_addr, cur.addr);
          if (cur.we) chk_eq("mem_wdata", mem_wdata, cur.wdata);
        end
      end
      if (busy) begin
        if (!hold_ack && !acked) begin
          if (cnt == 0) begin
            chk_eq("mem_addr_held", mem_addr, cur.addr);
            mem_ack = 1'b1;
            acked = 1'b1;
            if (mem_we) bmem[mem_addr] = mem_wdata;
            else mem_rdata = bmem_rd(mem_addr);
          end else begin
            cnt--;
          end
        end
      end else if (!reset && !mem_req && $urandom_range(0, 5) == 0) begin
        mem_ack = 1'b1;
        mem_rdata = $urandom;
      end
    end
  end

  logic [31:0] pool [5];

  initial begin
    logic [31:0] a;
    logic [TW-1:0] tg;
    logic [IB-1:0] ix;
    int n;
    pool[0] = 32'h0;
    pool[1] = 32'h1;
    pool[2] = 32'h2;
    pool[3] = 32'h3;
    pool[4] = 32'h00FF_FFFF;
    reset = 1'b1;
    cpu_req = 1'b0;
    cpu_we = 1'b0;
    cpu_addr = '0;
    cpu_wdata = '0;
    bmem[32'h40] = 32'hDEAD_BEEF;
    ref_mem[32'h40] = 32'hDEAD_BEEF;
    repeat (3) @(negedge clk);
    chk_eq("rst_cpu_ready", 32'(cpu_ready), 32'd0);
    chk_eq("rst_mem_req", 32'(mem_req), 32'd0);
    chk_eq("rst_mem_we", 32'(mem_we), 32'd0);
    chk_eq("rst_cpu_rdata", cpu_rdata, 32'd0);
    chk_eq("rst_mem_addr", mem_addr, 32'd0);
    chk_eq("rst_mem_wdata", mem_wdata, 32'd0);
    reset = 1'b0;

    do_op(1'b0, 32'h40, 32'h0, 1'b0, 1'b1);
    do_op(1'b0, 32'h40, 32'h0, 1'b1, 1'b1);
    do_op(1'b1, 32'h44, 32'h1234_5678, 1'b0, 1'b1);
    do_op(1'b0, 32'h44, 32'h0, 1'b0, 1'b1);
    do_op(1'b0, 32'h40, 32'h0, 1'b1, 1'b1);
    do_op(1'b0, 32'h140, 32'h0, 1'b0, 1'b1);
    do_op(1'b0, 32'h40, 32'h0, 1'b1, 1'b1);
    do_op(1'b0, 32'h43, 32'h0, 1'b1, 1'b1);

    for (int i = 0; i < 300; i++) begin
      tg = pool[$urandom_range(0, 4)][TW-1:0];
      ix = ($urandom_range(0, 3) == 0) ? IB'($urandom) : IB'($urandom_range(0, 7));
      a  = {tg, ix, 2'($urandom)};
      do_op(($urandom_range(0, 9) < 3), a, $urandom, bit'($urandom_range(0, 1)), 1'b1);
    end

`ifdef DMEM_CACHE_STATS_EN
    @(negedge clk);
    chk_eq("rd_hit_cnt", rd_hit_cnt, n_hit);
    chk_eq("rd_miss_cnt", rd_miss_cnt, n_miss);
    chk_eq("wr_cnt", wr_cnt, n_wr);
`endif

    // abandon a read miss with reset while memory withholds the ack
    a = 32'hABC0_0100;
    hold_ack = 1'b1;
    do_op(1'b0, a, 32'h0, 1'b0, 1'b0);
    n = 0;
    while (!mem_req && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk_eq("miss_mem_req_up", 32'(mem_req), 32'd1);
    repeat (3) @(negedge clk);
    chk_eq("miss_mem_req_held", 32'(mem_req), 32'd1);
    reset = 1'b1;
    #1;
    chk_eq("async_rst_mem_req", 32'(mem_req), 32'd0);
    chk_eq("async_rst_cpu_ready", 32'(cpu_ready), 32'd0);
    exp_q.delete();
    mexp_q.delete();
    hold_ack = 1'b0;
    cpu_req = 1'b0;
    for (int i = 0; i < NL; i++) ref_v[i] = 1'b0;
    n_hit = 0;
    n_miss = 0;
    n_wr = 0;
    @(negedge clk);
    reset = 1'b0;
    do_op(1'b0, a, 32'h0, 1'b0, 1'b1);
    do_op(1'b0, a, 32'h0, 1'b1, 1'b1);
    do_op(1'b0, 32'h40, 32'h0, 1'b0, 1'b1);
    do_op(1'b1, 32'h40, 32'hCAFE_F00D, 1'b1, 1'b1);
    do_op(1'b0, 32'h40, 32'h0, 1'b1, 1'b1);
    cpu_req = 1'b0;
    repeat (3) @(negedge clk);

    chk_eq("exp_q_drained", exp_q.size(), 32'd0);
    chk_eq("mexp_q_drained", mexp_q.size(), 32'd0);

`ifdef DMEM_CACHE_STATS_EN
    chk_eq("post_rst_hit_cnt", rd_hit_cnt, n_hit);
    chk_eq("post_rst_miss_cnt", rd_miss_cnt, n_miss);
    chk_eq("post_rst_wr_cnt", wr_cnt, n_wr);
    force dut.hit_cnt_q = 32'hFFFF_FFFE;
    #1;
    release dut.hit_cnt_q;
    do_op(1'b0, 32'h40, 32'h0, 1'b0, 1'b1);
    do_op(1'b0, 32'h40, 32'h0, 1'b0, 1'b1);
    cpu_req = 1'b0;
    @(negedge clk);
    chk_eq("hit_cnt_saturate", rd_hit_cnt, 32'hFFFF_FFFF);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/dmem_cache.md
Name: dmem_cache

Overview:
- Parametrised direct-mapped, write-through, write-allocate data cache between the CPU data port and a multi-cycle backing memory.
- Replaces the combinational single-cycle data-memory model with a handshake-based block: read hits return in one cycle, misses and all writes stall via req/ready.
- Cache lines are one word. Index width, tag width and data width all derive from parameters.

Parameters:
- ADDR_W, 32, byte address width.
- DATA_W, 32, word width. Must be 32 for byte offset = 2.
- INDEX_BITS, 6, log2 of line count (default 64 lines).
- Derived: TAG_W = ADDR_W - INDEX_BITS - 2. Index = addr[INDEX_BITS+1:2]. Tag = addr[ADDR_W-1:INDEX_BITS+2].

Ports:
- clk  in  1  rising-edge clock.
- reset  in  1  asynchronous, active-high reset.
- cpu_req  in  1  request valid. Held, with operands stable, until cpu_ready.
- cpu_we  in  1  1 = write, 0 = read.
- cpu_addr  in  ADDR_W  byte address. Bits [1:0] ignored.
- cpu_wdata  in  DATA_W  write data.
- cpu_rdata  out  DATA_W  read data, valid while cpu_ready=1 on a read.
- cpu_ready  out  1  one-cycle completion pulse.
- mem_req  out  1  backing-memory request. Held until mem_ack.
- mem_we  out  1  backing write.
- mem_addr  out  ADDR_W  word-aligned byte address ([1:0]=0).
- mem_wdata  out  DATA_W  backing write data.
- mem_rdata  in  DATA_W  backing read data, valid with mem_ack.
- mem_ack  in  1  backing completion, one-cycle pulse.

Behaviour:
- Reset (async): state=IDLE; all VALID bits cleared; cpu_ready, mem_req, mem_we=0; cpu_rdata, mem_addr, mem_wdata=0. Tag and data arrays are not cleared.
- Reset mid-miss or mid-write: the transaction is abandoned and mem_req drops immediately. No cache update occurs for the abandoned transaction.
- All outputs are registered. States: IDLE, RD_MISS, WR_THRU.
- IDLE accepts a request at a posedge only when cpu_req=1 and cpu_ready=0. cpu_ready=0 here means the previous completion cycle has passed, so at most one request is accepted every 2 cycles.
- Read hit (VALID[idx] and TAG[idx]==tag): cpu_rdata<=DATA[idx], cpu_ready<=1, stay in IDLE. Latency: 1 cycle from accept edge to ready.
- Read miss: mem_req<=1, mem_we<=0, mem_addr<=aligned addr, go to RD_MISS.
- RD_MISS, at posedge with mem_ack=1: DATA[idx]<=mem_rdata, TAG[idx]<=tag, VALID[idx]<=1, cpu_rdata<=mem_rdata, cpu_ready<=1, mem_req<=0, go to IDLE. With mem_ack=0 the block holds every output.
- Write (hit or miss): at the accept edge, DATA[idx]<=cpu_wdata, TAG[idx]<=tag, VALID[idx]<=1. Also mem_req<=1, mem_we<=1, mem_addr, mem_wdata<=cpu_wdata. Go to WR_THRU.
- WR_THRU, on mem_ack: cpu_ready<=1, mem_req<=0, mem_we<=0, go to IDLE.
- Conflict miss overwrites the resident line. No writeback is needed because the cache is write-through.
- mem_ack in IDLE is ignored. cpu_req outside IDLE is ignored (no queueing).
- mem_ack in the same cycle that mem_req rises cannot occur: the backing memory samples mem_req registered, so the minimum miss latency is 2 cycles.
- Tag compare uses ==. VALID must be 0/1 after reset; there is no X-compare.

Optional Feature:
- Macro: DMEM_CACHE_STATS_EN.
- Defined: adds outputs rd_hit_cnt, rd_miss_cnt, wr_cnt, each 32 bits.
  - Each increments by 1 at its event edge: rd_hit_cnt at read-hit accept, rd_miss_cnt at miss accept, wr_cnt at write accept.
  - Counters saturate at 0xFFFFFFFF.
  - Cleared by reset.
- Undefined: ports and counters are absent; behaviour is otherwise identical.

Test Plan:
- Reset, then read 0x0000_0040 with memory returning 0xDEADBEEF after 3 cycles -> mem_req high 3 cycles with mem_addr=0x40; cpu_ready pulses with cpu_rdata=0xDEADBEEF. Repeat read -> cpu_ready one cycle after accept, no mem_req, same data.
- Write 0x12345678 to 0x44 -> mem_req/mem_we asserted with mem_wdata=0x12345678 until ack; then read 0x44 -> hit (no mem_req), cpu_rdata=0x12345678.
- Conflict: read 0x40 (fill), read 0x140 (same index 16, tag 1) -> miss. Read 0x40 again -> miss. Each miss drives mem_addr correctly.
- Assert reset during RD_MISS with mem_ack withheld -> mem_req falls asynchronously, cpu_ready=0. Read of the same address afterwards misses (VALID cleared).
- cpu_req held high across cpu_ready on a hit -> next accept occurs one cycle after ready, never on the ready cycle. Spurious mem_ack in IDLE -> no state change.
- With DMEM_CACHE_STATS_EN: 2 misses, 3 hits, 1 write -> rd_miss_cnt=2, rd_hit_cnt=3, wr_cnt=1. Preload rd_hit_cnt near max via force -> it saturates at 0xFFFFFFFF.
